// File: rtl/ls597_scan_ctrl_if.sv
// Host and '597 pin bundle for the scan controller.
// The master side is the controller; the slave side is the host together with the '597 chain.
interface ls597_scan_ctrl_if #(
  parameter int NDEV = 1
);
  logic                start;
  logic                busy;
  logic                dvalid;
  logic [8*NDEV-1:0]   dout;
  logic                qh;
  logic                rck;
  logic                cload;
  logic                sck;
  logic                sclr;

  modport master (
    input  start, qh,
    output busy, dvalid, dout, rck, cload, sck, sclr
  );

  modport slave (
    output start, qh,
    input  busy, dvalid, dout, rck, cload, sck, sclr
  );
endinterface

// File: rtl/ls597_scan_ctrl.sv
// Sequencer for a daisy chain of sn74ls597 shift registers.
// Each scan latches the inputs, loads the chain, shifts out 8*NDEV bits and presents them as one word.
//
// state | meaning
// IDLE  | waiting for start; pins at rest
// RHI   | rck high, latching the parallel inputs
// RLO   | rck low
// LDLO  | cload low, storage copied into the shift register
// LDHI  | cload high
// SLO   | sck low; qh is sampled on the last cycle
// SHI   | sck high, the chain shifts by one bit
// DONE  | one cycle: dout updated, dvalid high
module ls597_scan_ctrl #(
  parameter int NDEV = 1,
  parameter int DIV  = 1
) (
  input  logic                     clk,
  input  logic                     clr,
  ls597_scan_ctrl_if.master        bus
);
  localparam int N  = 8 * NDEV;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(N + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N);

  typedef enum logic [2:0] {IDLE, RHI, RLO, LDLO, LDHI, SLO, SHI, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [N-1:0]  shadow_q, shadow_d;
  logic [N-1:0]  dout_q, dout_d;
  logic          busy_q, busy_d;
  logic          dvalid_q, dvalid_d;
  logic          rck_q, rck_d;
  logic          cload_q, cload_d;
  logic          sck_q, sck_d;
  logic          sclr_q, sclr_d;
  logic          ph_last;

  assign ph_last = (ph_q == PH_LAST);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      bit_q    <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      dvalid_q <= 1'b0;
      rck_q    <= 1'b0;
      cload_q  <= 1'b1;
      sck_q    <= 1'b0;
      sclr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      dvalid_q <= dvalid_d;
      rck_q    <= rck_d;
      cload_q  <= cload_d;
      sck_q    <= sck_d;
      sclr_q   <= sclr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        ph_d  = '0;
        bit_d = '0;
        if (bus.start) state_d = RHI;
      end
      DONE: state_d = IDLE;
      default: begin
        if (ph_last) begin
          ph_d = '0;
          case (state_q)
            RHI:  state_d = RLO;
            RLO:  state_d = LDLO;
            LDLO: state_d = LDHI;
            LDHI: state_d = SLO;
            SLO: begin
              state_d  = SHI;
              shadow_d = {shadow_q[N-2:0], bus.qh};
            end
            SHI: begin
              bit_d   = bit_q + 1'b1;
              state_d = (bit_d == BIT_LAST) ? DONE : SLO;
            end
            default: state_d = IDLE;
          endcase
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
    endcase
  end

  // Pin levels are derived from the next state so the registered pins line up with state_q.
  always_comb begin
    rck_d    = (state_d == RHI);
    cload_d  = (state_d != LDLO);
    sck_d    = (state_d == SHI);
    busy_d   = (state_d != IDLE);
    dvalid_d = (state_d == DONE);
    dout_d   = (state_d == DONE) ? shadow_q : dout_q;
    sclr_d   = 1'b1;
  end

  assign bus.busy   = busy_q;
  assign bus.dvalid = dvalid_q;
  assign bus.dout   = dout_q;
  assign bus.rck    = rck_q;
  assign bus.cload  = cload_q;
  assign bus.sck    = sck_q;
  assign bus.sclr   = sclr_q;
endmodule

// File: tb/tb_ls597_scan_ctrl.sv
// Directed bench for ls597_scan_ctrl with behavioural '597 chains.
// Instance A: NDEV=1, DIV=1. Instance B: NDEV=2, DIV=2.
module tb_ls597_scan_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ls597_scan_ctrl_if #(.NDEV(1)) ifa ();
  ls597_scan_ctrl_if #(.NDEV(2)) ifb ();

  ls597_scan_ctrl #(.NDEV(1), .DIV(1)) dut_a (.clk(clk), .clr(clr), .bus(ifa.master));
  ls597_scan_ctrl #(.NDEV(2), .DIV(2)) dut_b (.clk(clk), .clr(clr), .bus(ifb.master));

  // '597 chain models; in_b is {nearest device, far device}
  logic [7:0]  in_a = 8'h00, stor_a, sh_a;
  logic [15:0] in_b = 16'h0000, stor_b, sh_b;

  always @(posedge ifa.rck) stor_a <= in_a;
  always @(posedge ifa.sck or negedge ifa.cload or negedge ifa.sclr)
    if (!ifa.sclr)       sh_a <= '0;
    else if (!ifa.cload) sh_a <= stor_a;
    else                 sh_a <= {sh_a[6:0], 1'b0};
  assign ifa.qh = sh_a[7];

  always @(posedge ifb.rck) stor_b <= in_b;
  always @(posedge ifb.sck or negedge ifb.cload or negedge ifb.sclr)
    if (!ifb.sclr)       sh_b <= '0;
    else if (!ifb.cload) sh_b <= stor_b;
    else                 sh_b <= {sh_b[14:0], 1'b0};
  assign ifb.qh = sh_b[15];

  int rck_e_a = 0, sck_e_a = 0, cload_lo_a = 0, dv_n_a = 0;
  int rck_e_b = 0, sck_e_b = 0, cload_lo_b = 0, rck_hi_b = 0, sck_hi_b = 0;

  always @(posedge ifa.rck) rck_e_a <= rck_e_a + 1;
  always @(posedge ifa.sck) sck_e_a <= sck_e_a + 1;
  always @(posedge ifb.rck) rck_e_b <= rck_e_b + 1;
  always @(posedge ifb.sck) sck_e_b <= sck_e_b + 1;
  always @(negedge clk) begin
    if (!ifa.cload) cload_lo_a <= cload_lo_a + 1;
    if (ifa.dvalid) dv_n_a     <= dv_n_a + 1;
    if (!ifb.cload) cload_lo_b <= cload_lo_b + 1;
    if (ifb.rck)    rck_hi_b   <= rck_hi_b + 1;
    if (ifb.sck)    sck_hi_b   <= sck_hi_b + 1;
  end

  task automatic scan_a(input int budget, output bit ok, output int lat, output logic [7:0] d);
    int s;
    ok = 1'b0; lat = 0; d = '0;
    @(negedge clk); ifa.start = 1'b1; s = cyc + 1;
    @(negedge clk); ifa.start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ifa.dvalid) begin ok = 1'b1; lat = cyc - s; d = ifa.dout; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; ifa.start = 1'b0; ifb.start = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if ({ifa.busy, ifa.dvalid, ifa.rck, ifa.cload, ifa.sck, ifa.sclr} !== 6'b000100) begin
      fails++; $display("FAIL reset_pins_a got %b want 000100", {ifa.busy, ifa.dvalid, ifa.rck, ifa.cload, ifa.sck, ifa.sclr}); end
    tests++; if (ifa.dout !== 8'h00) begin fails++; $display("FAIL reset_dout_a got %h want 00", ifa.dout); end
    tests++; if ({ifb.busy, ifb.dvalid, ifb.rck, ifb.cload, ifb.sck, ifb.sclr} !== 6'b000100) begin
      fails++; $display("FAIL reset_pins_b got %b want 000100", {ifb.busy, ifb.dvalid, ifb.rck, ifb.cload, ifb.sck, ifb.sclr}); end
    tests++; if (ifb.dout !== 16'h0000) begin fails++; $display("FAIL reset_dout_b got %h want 0000", ifb.dout); end
    clr = 1'b1;
    #1;
    tests++; if ({ifa.sclr, ifb.sclr} !== 2'b00) begin fails++; $display("FAIL sclr_before_edge got %b want 00", {ifa.sclr, ifb.sclr}); end
    @(posedge clk); #1;
    tests++; if ({ifa.sclr, ifb.sclr} !== 2'b11) begin fails++; $display("FAIL sclr_after_edge got %b want 11", {ifa.sclr, ifb.sclr}); end
  endtask

  task automatic test_scan_a();
    bit ok; int lat; logic [7:0] d;
    int r0, c0, s0;
    in_a = 8'hA5;
    r0 = rck_e_a; c0 = cload_lo_a; s0 = sck_e_a;
    scan_a(60, ok, lat, d);
    tests++; if (!ok) begin fails++; $display("FAIL scan_a_timeout got no dvalid want dvalid"); end
    tests++; if (lat != 20) begin fails++; $display("FAIL scan_a_latency got %0d want 20", lat); end
    tests++; if (d !== 8'hA5) begin fails++; $display("FAIL scan_a_dout got %h want a5", d); end
    tests++; if (ifa.busy !== 1'b1) begin fails++; $display("FAIL scan_a_busy_done got %b want 1", ifa.busy); end
    @(negedge clk);
    tests++; if ({ifa.busy, ifa.dvalid} !== 2'b00) begin fails++; $display("FAIL scan_a_after_done got %b want 00", {ifa.busy, ifa.dvalid}); end
    repeat (3) @(negedge clk);
    tests++; if (rck_e_a - r0 != 1) begin fails++; $display("FAIL scan_a_rck_edges got %0d want 1", rck_e_a - r0); end
    tests++; if (cload_lo_a - c0 != 1) begin fails++; $display("FAIL scan_a_cload_low got %0d want 1", cload_lo_a - c0); end
    tests++; if (sck_e_a - s0 != 8) begin fails++; $display("FAIL scan_a_sck_edges got %0d want 8", sck_e_a - s0); end
    tests++; if (ifa.dout !== 8'hA5) begin fails++; $display("FAIL scan_a_dout_hold got %h want a5", ifa.dout); end
  endtask

  task automatic test_scan_b();
    bit ok; int s, lat; logic [15:0] d;
    int r0, rh0, c0, s0, sh0;
    in_b = 16'h3C81;
    r0 = rck_e_b; rh0 = rck_hi_b; c0 = cload_lo_b; s0 = sck_e_b; sh0 = sck_hi_b;
    ok = 1'b0; lat = 0; d = '0;
    @(negedge clk); ifb.start = 1'b1; s = cyc + 1;
    @(negedge clk); ifb.start = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (ifb.dvalid) begin ok = 1'b1; lat = cyc - s; d = ifb.dout; break; end
      @(negedge clk);
    end
    tests++; if (!ok) begin fails++; $display("FAIL scan_b_timeout got no dvalid want dvalid"); end
    tests++; if (lat != 72) begin fails++; $display("FAIL scan_b_latency got %0d want 72", lat); end
    tests++; if (d !== 16'h3C81) begin fails++; $display("FAIL scan_b_dout got %h want 3c81", d); end
    repeat (3) @(negedge clk);
    tests++; if (sck_e_b - s0 != 16) begin fails++; $display("FAIL scan_b_sck_edges got %0d want 16", sck_e_b - s0); end
    tests++; if (sck_hi_b - sh0 != 32) begin fails++; $display("FAIL scan_b_sck_high got %0d want 32", sck_hi_b - sh0); end
    tests++; if (rck_e_b - r0 != 1 || rck_hi_b - rh0 != 2) begin
      fails++; $display("FAIL scan_b_rck got edges %0d high %0d want 1 2", rck_e_b - r0, rck_hi_b - rh0); end
    tests++; if (cload_lo_b - c0 != 2) begin fails++; $display("FAIL scan_b_cload_low got %0d want 2", cload_lo_b - c0); end
  endtask

  task automatic test_start_while_busy();
    bit ok; int s0, v0;
    in_a = 8'h5A;
    s0 = sck_e_a; v0 = dv_n_a; ok = 1'b0;
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    repeat (5) @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ifa.dvalid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    repeat (30) @(negedge clk);
    tests++; if (!ok) begin fails++; $display("FAIL busy_start_timeout got no dvalid want dvalid"); end
    tests++; if (sck_e_a - s0 != 8) begin fails++; $display("FAIL busy_start_sck got %0d want 8", sck_e_a - s0); end
    tests++; if (dv_n_a - v0 != 1) begin fails++; $display("FAIL busy_start_dvalids got %0d want 1", dv_n_a - v0); end
    tests++; if (ifa.dout !== 8'h5A) begin fails++; $display("FAIL busy_start_dout got %h want 5a", ifa.dout); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2; int t1, t2; logic [7:0] d1, d2;
    ok1 = 1'b0; ok2 = 1'b0; t1 = 0; t2 = 0; d1 = '0; d2 = '0;
    in_a = 8'h0F;
    @(negedge clk); ifa.start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifa.dvalid) begin ok1 = 1'b1; t1 = cyc; d1 = ifa.dout; break; end
    end
    in_a = 8'hF0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifa.dvalid) begin ok2 = 1'b1; t2 = cyc; d2 = ifa.dout; break; end
    end
    ifa.start = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (!(ok1 && ok2)) begin fails++; $display("FAIL b2b_timeout got %b%b want 11", ok1, ok2); end
    tests++; if (t2 - t1 != 22) begin fails++; $display("FAIL b2b_period got %0d want 22", t2 - t1); end
    tests++; if (d1 !== 8'h0F) begin fails++; $display("FAIL b2b_first got %h want 0f", d1); end
    tests++; if (d2 !== 8'hF0) begin fails++; $display("FAIL b2b_second got %h want f0", d2); end
    tests++; if (ifa.busy !== 1'b0) begin fails++; $display("FAIL b2b_idle got %b want 0", ifa.busy); end
  endtask

  task automatic test_reset_mid_scan();
    bit ok, hit; int lat, s0, v0; logic [7:0] d;
    in_a = 8'hC3;
    s0 = sck_e_a; hit = 1'b0;
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sck_e_a - s0 == 3) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    clr = 1'b0;
    #1;
    tests++; if (!hit) begin fails++; $display("FAIL midrst_timeout got %0d sck edges want 3", sck_e_a - s0); end
    tests++; if ({ifa.busy, ifa.dvalid, ifa.rck, ifa.cload, ifa.sck, ifa.sclr} !== 6'b000100) begin
      fails++; $display("FAIL midrst_pins got %b want 000100", {ifa.busy, ifa.dvalid, ifa.rck, ifa.cload, ifa.sck, ifa.sclr}); end
    tests++; if (ifa.dout !== 8'h00) begin fails++; $display("FAIL midrst_dout got %h want 00", ifa.dout); end
    v0 = dv_n_a;
    repeat (4) @(negedge clk);
    clr = 1'b1;
    repeat (30) @(negedge clk);
    tests++; if (dv_n_a != v0) begin fails++; $display("FAIL midrst_dvalid got %0d want 0", dv_n_a - v0); end
    s0 = sck_e_a;
    scan_a(60, ok, lat, d);
    repeat (3) @(negedge clk);
    tests++; if (!ok || d !== 8'hC3) begin fails++; $display("FAIL midrst_rescan got ok=%b %h want ok=1 c3", ok, d); end
    tests++; if (lat != 20) begin fails++; $display("FAIL midrst_latency got %0d want 20", lat); end
    tests++; if (sck_e_a - s0 != 8) begin fails++; $display("FAIL midrst_sck got %0d want 8", sck_e_a - s0); end
  endtask

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    test_reset();
    test_scan_a();
    test_scan_b();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
